cpu_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 8-bit microprocessor datapath (4 GPRs, 32-byte data memory, PC/IR).

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/cpu_decode.sv | 20 ++
 rtl/cpu_sequencer.sv | 141 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU control path: FSM states, opcodes and decode bundle.
package cpu_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BR  = 2'b11;

  // Branch-to-self is treated as halt.
  localparam logic [7:0] HLT_INSTR = 8'hFF;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic is_load;
    logic is_store;
    logic is_br;
    logic is_hlt;
  } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// Static instruction decode: IR -> datapath selects and opcode class flags.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output dec_t       dec
);

  always_comb begin
    dec            = '0;
    dec.reg_dst    = ~ir[6];
    dec.alu_src    = ir[7] ^ ir[6];
    dec.mem_to_reg = ir[6];
    dec.is_load    = (ir[7:6] == OP_LW);
    dec.is_store   = (ir[7:6] == OP_SW);
    dec.is_br      = (ir[7:6] == OP_BR);
    dec.is_hlt     = (ir == HLT_INSTR);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch handshake, decode, per-phase one-tick datapath enables,
// run/step/halt control, fetch timeout and retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int COUNT_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic               imem_ack,
  input  logic [7:0]         instruction,
  output logic               imem_req,
  output logic               ir_load,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_dst,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               pc_inc,
  output logic               pc_branch,
  output logic [2:0]         state,
  output logic               halted,
  output logic               fault,
  output logic [COUNT_W-1:0] retired
);

  localparam int TO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(FETCH_TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic [7:0]         ir_q, ir_d;
  logic [TO_W-1:0]    timeout_q, timeout_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic               step_mode_q, step_mode_d;
  logic               halt_pend_q, halt_pend_d;
  logic               retire;
  logic               dec_valid;
  dec_t               dec;

  cpu_decode u_decode (.ir(ir_q), .dec(dec));

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    timeout_d   = (state_q == S_FETCH) ? timeout_q : '0;
    retired_d   = retired_q;
    step_mode_d = step_mode_q;
    halt_pend_d = halt_pend_q | (halt_req & (state_q != S_IDLE));
    ir_load     = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    retire      = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: if (run || step) begin
          state_d     = S_FETCH;
          step_mode_d = ~run;
        end
        S_FETCH: if (imem_ack) begin
          ir_load   = 1'b1;
          ir_d      = instruction;
          timeout_d = '0;
          state_d   = S_DECODE;
        end else if (timeout_q == TO_MAX) begin
          state_d = S_FAULT;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
        S_DECODE: state_d = dec.is_hlt ? S_HALTED : S_EXEC;
        S_EXEC: if (dec.is_br) begin
          pc_branch = 1'b1;
          retire    = 1'b1;
        end else begin
          state_d = (dec.is_load || dec.is_store) ? S_MEM : S_WB;
        end
        S_MEM: if (dec.is_store) begin
          mem_write = 1'b1;
          pc_inc    = 1'b1;
          retire    = 1'b1;
        end else begin
          state_d = S_WB;
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_inc    = 1'b1;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
    // Retire resolves the NEXT pseudo-state; a halt_req arriving this tick still counts.
    if (retire) begin
      retired_d = retired_q + 1'b1;
      if (step_mode_q || halt_pend_d || !run) begin
        state_d     = S_IDLE;
        halt_pend_d = 1'b0;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      timeout_q   <= '0;
      retired_q   <= '0;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      timeout_q   <= timeout_d;
      retired_q   <= retired_d;
      step_mode_q <= step_mode_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign dec_valid  = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_MEM)    || (state_q == S_WB);
  assign reg_dst    = dec_valid & dec.reg_dst;
  assign alu_src    = dec_valid & dec.alu_src;
  assign mem_to_reg = dec_valid & dec.mem_to_reg;
  assign imem_req   = (state_q == S_FETCH);
  assign mem_read   = (state_q == S_MEM) & dec.is_load;
  assign state      = state_q;
  assign halted     = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign fault      = (state_q == S_FAULT);
  assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: step/run flows, branch/halt, fetch timeout, tick gating, halt_req, reset.
module tb_cpu_sequencer;

  logic       clock, reset, tick, run, step, halt_req, imem_ack;
  logic [7:0] instruction;
  logic       imem_req, ir_load, reg_write, mem_read, mem_write;
  logic       reg_dst, alu_src, mem_to_reg, pc_inc, pc_branch;
  logic [2:0] state;
  logic       halted, fault;
  logic [7:0] retired;

  int total = 0;
  int bad   = 0;

  // {imem_req, ir_load, reg_write, mem_read, mem_write, pc_inc, pc_branch}
  wire [6:0] pv  = {imem_req, ir_load, reg_write, mem_read, mem_write, pc_inc, pc_branch};
  wire [2:0] dsv = {reg_dst, alu_src, mem_to_reg};

  cpu_sequencer #(.FETCH_TIMEOUT(16), .COUNT_W(8)) dut (
    .clock(clock), .reset(reset), .tick(tick), .run(run), .step(step),
    .halt_req(halt_req), .imem_ack(imem_ack), .instruction(instruction),
    .imem_req(imem_req), .ir_load(ir_load), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .pc_inc(pc_inc),
    .pc_branch(pc_branch), .state(state), .halted(halted), .fault(fault),
    .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic nc();
    @(negedge clock);
  endtask

  task automatic do_reset();
    nc(); reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; tick = 1'b1;
    nc(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; run = 1'b1; step = 1'b1; halt_req = 1'b0; imem_ack = 1'b1;
    instruction = 8'h00;
    nc(); nc(); reset = 1'b0; run = 1'b0; step = 1'b0; imem_ack = 1'b0; #1;
    total++; if ({state, pv, dsv} !== {3'd0, 7'b0, 3'b0}) begin bad++;
      $display("FAIL reset_outputs state=%0d pv=%b dec=%b exp state=0 pv=0 dec=0", state, pv, dsv); end
    total++; if ({halted, fault, retired} !== {1'b1, 1'b0, 8'd0}) begin bad++;
      $display("FAIL reset_status halted=%b fault=%b retired=%0d exp 1 0 0", halted, fault, retired); end
  endtask

  task automatic test_step_add();
    nc(); tick = 1'b1; step = 1'b1; #1;
    nc(); step = 1'b0; imem_ack = 1'b1; instruction = 8'h1B; #1;
    total++; if ({state, pv} !== {3'd1, 7'b1100000}) begin bad++;
      $display("FAIL add_fetch state=%0d pv=%b exp 1 1100000", state, pv); end
    nc(); imem_ack = 1'b0; #1;
    total++; if ({state, pv, dsv} !== {3'd2, 7'b0, 3'b100}) begin bad++;
      $display("FAIL add_decode state=%0d pv=%b dec=%b exp 2 0000000 100", state, pv, dsv); end
    nc(); #1;
    total++; if ({state, pv} !== {3'd3, 7'b0}) begin bad++;
      $display("FAIL add_exec state=%0d pv=%b exp 3 0000000", state, pv); end
    nc(); #1;
    total++; if ({state, pv} !== {3'd5, 7'b0010010}) begin bad++;
      $display("FAIL add_wb state=%0d pv=%b exp 5 0010010", state, pv); end
    nc(); #1;
    total++; if ({state, pv, halted, retired} !== {3'd0, 7'b0, 1'b1, 8'd1}) begin bad++;
      $display("FAIL add_done state=%0d pv=%b halted=%b retired=%0d exp 0 0 1 1", state, pv, halted, retired); end
  endtask

  task automatic test_run_lw_sw();
    nc(); run = 1'b1; #1;
    nc(); imem_ack = 1'b1; instruction = 8'h46; #1;
    total++; if ({state, pv} !== {3'd1, 7'b1100000}) begin bad++;
      $display("FAIL lw_fetch state=%0d pv=%b exp 1 1100000", state, pv); end
    nc(); imem_ack = 1'b0; #1;
    total++; if ({state, dsv} !== {3'd2, 3'b011}) begin bad++;
      $display("FAIL lw_decode state=%0d dec=%b exp 2 011", state, dsv); end
    nc(); #1;
    nc(); #1;
    total++; if ({state, pv} !== {3'd4, 7'b0001000}) begin bad++;
      $display("FAIL lw_mem state=%0d pv=%b exp 4 0001000", state, pv); end
    nc(); #1;
    total++; if ({state, pv} !== {3'd5, 7'b0010010}) begin bad++;
      $display("FAIL lw_wb state=%0d pv=%b exp 5 0010010", state, pv); end
    nc(); imem_ack = 1'b1; instruction = 8'h86; #1;
    total++; if ({state, pv, retired} !== {3'd1, 7'b1100000, 8'd2}) begin bad++;
      $display("FAIL sw_fetch state=%0d pv=%b retired=%0d exp 1 1100000 2", state, pv, retired); end
    nc(); imem_ack = 1'b0; #1;
    total++; if ({state, dsv} !== {3'd2, 3'b110}) begin bad++;
      $display("FAIL sw_decode state=%0d dec=%b exp 2 110", state, dsv); end
    nc(); #1;
    nc(); run = 1'b0; #1;
    total++; if ({state, pv} !== {3'd4, 7'b0000110}) begin bad++;
      $display("FAIL sw_mem state=%0d pv=%b exp 4 0000110", state, pv); end
    nc(); #1;
    total++; if ({state, halted, retired} !== {3'd0, 1'b1, 8'd3}) begin bad++;
      $display("FAIL sw_done state=%0d halted=%b retired=%0d exp 0 1 3", state, halted, retired); end
  endtask

  task automatic test_br_hlt();
    nc(); run = 1'b1; #1;
    nc(); imem_ack = 1'b1; instruction = 8'hC1; #1;
    nc(); imem_ack = 1'b0; #1;
    nc(); #1;
    total++; if ({state, pv} !== {3'd3, 7'b0000001}) begin bad++;
      $display("FAIL br_exec state=%0d pv=%b exp 3 0000001", state, pv); end
    nc(); imem_ack = 1'b1; instruction = 8'hFF; #1;
    total++; if ({state, pv, retired} !== {3'd1, 7'b1100000, 8'd4}) begin bad++;
      $display("FAIL br_next state=%0d pv=%b retired=%0d exp 1 1100000 4", state, pv, retired); end
    nc(); imem_ack = 1'b0; #1;
    nc(); step = 1'b1; #1;
    total++; if ({state, pv, halted, retired} !== {3'd6, 7'b0, 1'b1, 8'd4}) begin bad++;
      $display("FAIL hlt_state state=%0d pv=%b halted=%b retired=%0d exp 6 0 1 4", state, pv, halted, retired); end
    nc(); step = 1'b0; #1;
    total++; if ({state, pv} !== {3'd6, 7'b0}) begin bad++;
      $display("FAIL hlt_sticky state=%0d pv=%b exp 6 0", state, pv); end
    do_reset();
  endtask

  task automatic test_timeout();
    nc(); run = 1'b1; imem_ack = 1'b0; #1;
    for (int i = 1; i <= 16; i++) begin
      nc(); #1;
      if (i == 16) begin
        total++; if ({state, imem_req} !== {3'd1, 1'b1}) begin bad++;
          $display("FAIL to_last_fetch state=%0d req=%b exp 1 1", state, imem_req); end
      end
    end
    nc(); #1;
    total++; if ({state, fault, imem_req, halted} !== {3'd7, 1'b1, 1'b0, 1'b0}) begin bad++;
      $display("FAIL to_fault state=%0d fault=%b req=%b halted=%b exp 7 1 0 0", state, fault, imem_req, halted); end
    nc(); imem_ack = 1'b1; #1;
    total++; if ({state, fault} !== {3'd7, 1'b1}) begin bad++;
      $display("FAIL to_sticky state=%0d fault=%b exp 7 1", state, fault); end
    do_reset(); #1;
    total++; if ({state, fault, halted, retired} !== {3'd0, 1'b0, 1'b1, 8'd0}) begin bad++;
      $display("FAIL to_reset state=%0d fault=%b halted=%b retired=%0d exp 0 0 1 0", state, fault, halted, retired); end
  endtask

  task automatic test_tick_div();
    logic [2:0] st [6];
    logic [6:0] pt [6];
    logic [6:0] ep;
    int k;
    st[0] = 3'd0; st[1] = 3'd1; st[2] = 3'd2; st[3] = 3'd3; st[4] = 3'd5; st[5] = 3'd0;
    pt[0] = 7'b0; pt[1] = 7'b1100000; pt[2] = 7'b0; pt[3] = 7'b0; pt[4] = 7'b0010010; pt[5] = 7'b0;
    k = 0;
    for (int n = 0; n < 24; n++) begin
      nc(); tick = (n % 4 == 0); step = (k == 0); imem_ack = 1'b1; instruction = 8'h1B; #1;
      ep = tick ? pt[k] : ((st[k] == 3'd1) ? 7'b1000000 : 7'b0);
      total++; if ({state, pv} !== {st[k], ep}) begin bad++;
        $display("FAIL tick_div n=%0d state=%0d pv=%b exp %0d %b", n, state, pv, st[k], ep); end
      if (tick && k < 5) k++;
    end
    nc(); tick = 1'b1; imem_ack = 1'b0; #1;
    total++; if ({state, retired} !== {3'd0, 8'd1}) begin bad++;
      $display("FAIL tick_div_done state=%0d retired=%0d exp 0 1", state, retired); end
  endtask

  task automatic test_halt_req();
    nc(); run = 1'b1; #1;
    nc(); imem_ack = 1'b0; halt_req = 1'b1; #1;
    nc(); halt_req = 1'b0; imem_ack = 1'b1; instruction = 8'h1B; #1;
    total++; if ({state, pv} !== {3'd1, 7'b1100000}) begin bad++;
      $display("FAIL hr_fetch state=%0d pv=%b exp 1 1100000", state, pv); end
    nc(); imem_ack = 1'b0; #1;
    nc(); #1;
    nc(); #1;
    total++; if ({state, pv} !== {3'd5, 7'b0010010}) begin bad++;
      $display("FAIL hr_wb state=%0d pv=%b exp 5 0010010", state, pv); end
    nc(); #1;
    total++; if ({state, halted, retired} !== {3'd0, 1'b1, 8'd2}) begin bad++;
      $display("FAIL hr_idle state=%0d halted=%b retired=%0d exp 0 1 2", state, halted, retired); end
    nc(); imem_ack = 1'b1; instruction = 8'h46; #1;
    total++; if (state !== 3'd1) begin bad++;
      $display("FAIL hr_restart state=%0d exp 1", state); end
    nc(); imem_ack = 1'b0; #1;
    nc(); #1;
    nc(); reset = 1'b1; #1;
    total++; if ({state, mem_read} !== {3'd4, 1'b1}) begin bad++;
      $display("FAIL rst_in_mem_pre state=%0d mem_read=%b exp 4 1", state, mem_read); end
    nc(); reset = 1'b0; run = 1'b0; #1;
    total++; if ({state, pv, dsv, halted, fault, retired} !== {3'd0, 7'b0, 3'b0, 1'b1, 1'b0, 8'd0}) begin bad++;
      $display("FAIL rst_in_mem state=%0d pv=%b dec=%b halted=%b fault=%b retired=%0d exp 0 0 0 1 0 0",
               state, pv, dsv, halted, fault, retired); end
  endtask

  initial begin
    test_reset();
    test_step_add();
    test_run_lw_sw();
    test_br_hlt();
    test_timeout();
    test_tick_div();
    test_halt_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
